nibble_serial_cla_adder: RTL and testbench



---
 rtl/nibble_serial_cla_adder_pkg.sv | 13 +
 rtl/nibble_serial_cla_adder_cla_unit.sv | 27 ++
 rtl/nibble_serial_cla_adder.sv | 130 +++++++++++++
 tb/tb_nibble_serial_cla_adder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_cla_adder_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder:
// group width and FSM state encoding.
package nibble_serial_cla_adder_pkg;

    localparam int GROUP_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_cla_adder_cla_unit.sv
// Combinational 4-bit carry lookahead unit: expands bit P/G and a group
// carry-in into every bit carry as flat two-level sum-of-products.
module carry_lookahead_unit
    import nibble_serial_cla_adder_pkg::*;
(
    input  logic [GROUP_W-1:0] p,
    input  logic [GROUP_W-1:0] g,
    input  logic               c_in,
    output logic [GROUP_W:0]   c,
    output logic               grp_p,
    output logic               grp_g
);

    always_comb begin
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);
        grp_p = &p;
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

// File: rtl/nibble_serial_cla_adder.sv
// Multi-cycle adder resolving one 4-bit group per clock through a single
// shared lookahead unit, behind valid/ready operand and result interfaces.
module nibble_serial_cla_adder
    import nibble_serial_cla_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             prop_all
);

    localparam int NGRP  = WIDTH / GROUP_W;
    localparam int IDX_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic               carry_q, carry_d, prop_acc_q, prop_acc_d;
    logic               c_out_q, c_out_d, ovf_q, ovf_d, prop_all_q, prop_all_d;

    logic [GROUP_W-1:0] grp_pv, grp_gv;
    logic [GROUP_W:0]   cla_c;
    logic               cla_p, cla_g;

    carry_lookahead_unit u_cla (
        .p     (grp_pv),
        .g     (grp_gv),
        .c_in  (carry_q),
        .c     (cla_c),
        .grp_p (cla_p),
        .grp_g (cla_g)
    );

    always_comb begin
        grp_pv     = a_q[idx_q*GROUP_W +: GROUP_W] ^ b_q[idx_q*GROUP_W +: GROUP_W];
        grp_gv     = a_q[idx_q*GROUP_W +: GROUP_W] & b_q[idx_q*GROUP_W +: GROUP_W];
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        prop_acc_d = prop_acc_q;
        c_out_d    = c_out_q;
        ovf_d      = ovf_q;
        prop_all_d = prop_all_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    idx_d      = '0;
                    carry_d    = c_in;
                    prop_acc_d = 1'b1;
                    sum_d      = '0;
                    c_out_d    = 1'b0;
                    ovf_d      = 1'b0;
                    prop_all_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*GROUP_W +: GROUP_W] = grp_pv ^ cla_c[GROUP_W-1:0];
                // Group generate/propagate give the outgoing carry without
                // going through the bit carry chain.
                carry_d    = cla_g | (cla_p & carry_q);
                prop_acc_d = prop_acc_q & cla_p;
                if (idx_q == IDX_W'(NGRP - 1)) begin
                    c_out_d    = cla_c[GROUP_W];
                    ovf_d      = cla_c[GROUP_W-1] ^ cla_c[GROUP_W];
                    prop_all_d = prop_acc_q & cla_p;
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            prop_acc_q <= 1'b1;
            c_out_q    <= 1'b0;
            ovf_q      <= 1'b0;
            prop_all_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            prop_acc_q <= prop_acc_d;
            c_out_q    <= c_out_d;
            ovf_q      <= ovf_d;
            prop_all_q <= prop_all_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign overflow  = ovf_q;
    assign prop_all  = prop_all_q;

endmodule

// File: tb/tb_nibble_serial_cla_adder.sv
// Self-checking bench for nibble_serial_cla_adder: directed corner cases plus
// random operands compared against a plain-arithmetic reference model.
module tb_nibble_serial_cla_adder;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c_in = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             prop_all;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_cla_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow),
        .prop_all  (prop_all)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: ordinary wide addition and sign rules.
    function automatic logic [35:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                          input logic ci);
        logic [WIDTH:0]   t;
        logic             ov;
        t  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        ov = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
        return {1'b0, &(x ^ y), ov, t[WIDTH], t[WIDTH-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] x,
                                input logic [WIDTH-1:0] y, input logic ci);
        logic [35:0] m;
        m = model(x, y, ci);
        check({tag, ".sum"},  64'(sum),      64'(m[WIDTH-1:0]));
        check({tag, ".cout"}, 64'(c_out),    64'(m[WIDTH]));
        check({tag, ".ovf"},  64'(overflow), 64'(m[WIDTH+1]));
        check({tag, ".pall"}, 64'(prop_all), 64'(m[WIDTH+2]));
    endtask

    // Accept one operand pair and wait for the result; returns edges to out_valid.
    task automatic start_and_wait(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic ci, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin tick(); guard++; end
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        a = x; b = y; c_in = ci; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; c_in = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin tick(); lat++; end
    endtask

    task automatic full_txn(input string tag, input logic [WIDTH-1:0] x,
                            input logic [WIDTH-1:0] y, input logic ci);
        int lat;
        start_and_wait(x, y, ci, lat);
        check({tag, ".latency"}, 64'(lat), 64'(LAT));
        check_result(tag, x, y, ci);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".back_idle"}, 64'({in_ready, out_valid}), 64'b10);
    endtask

    initial begin : main
        int lat;
        logic [WIDTH-1:0] ra, rb;
        logic             rc;

        #2;
        check("reset.in_ready",  64'(in_ready),  64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.outs", 64'({sum, c_out, overflow, prop_all}), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        full_txn("t1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        full_txn("t2", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        full_txn("t3", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1);
        full_txn("t3b", 32'h8000_0000, 32'h8000_0000, 1'b0);

        // Backpressure with an ignored in_valid pulse during the stall.
        start_and_wait(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
        check("bp.latency", 64'(lat), 64'(LAT));
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            a = 32'hDEAD_BEEF; b = 32'h1;
            check("bp.sum_held", 64'(sum), 64'h2345_6789);
            check("bp.in_ready", 64'(in_ready), 64'd0);
            check("bp.out_valid", 64'(out_valid), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp.idle", 64'({in_ready, out_valid}), 64'b10);
        tick();
        check("bp.pulse_ignored", 64'({in_ready, sum}), {31'd0, 1'b1, 32'h2345_6789});

        // Reset after the 4th RUN edge.
        a = 32'hAAAA_AAAA; b = 32'h5555_5555; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rst.pre_state", 64'({in_ready, out_valid}), 64'b00);
        rst_n = 1'b0;
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.sum", 64'(sum), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        #2;
        rst_n = 1'b1;
        tick();
        full_txn("rst.after", 32'd3, 32'd5, 1'b0);

        // Random operands with random consumer delay.
        for (int k = 0; k < 12; k++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            if (k == 0) rb = ~ra;
            start_and_wait(ra, rb, rc, lat);
            check("rnd.latency", 64'(lat), 64'(LAT));
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
            check_result("rnd", ra, rb, rc);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // Back-to-back with in_valid and out_ready held high.
        begin
            logic [WIDTH-1:0] qa[$], qb[$];
            logic [WIDTH-1:0] ea, eb;
            int  sent, got, cyc, last_cyc;
            bit  acc_now;
            sent = 0; got = 0; cyc = 0; last_cyc = -1;
            ra = $urandom; rb = $urandom;
            a = ra; b = rb; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
            while (got < 3 && cyc < 100) begin
                acc_now = in_ready && in_valid;
                tick();
                cyc++;
                if (acc_now) begin
                    qa.push_back(a); qb.push_back(b);
                    sent++;
                    if (sent == 3) in_valid = 1'b0;
                    else begin a = $urandom; b = $urandom; end
                end
                if (out_valid) begin
                    ea = qa.pop_front(); eb = qb.pop_front();
                    check_result("b2b", ea, eb, 1'b0);
                    if (last_cyc >= 0) check("b2b.spacing", 64'(cyc - last_cyc), 64'(LAT + 2));
                    last_cyc = cyc;
                    got++;
                end
            end
            check("b2b.count", 64'(got), 64'd3);
            check("b2b.accepts", 64'(sent), 64'd3);
            out_ready = 1'b0;
            in_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
